// File: rtl/fixed_point_alu_seq_if.sv
// Operand/result bus of the sign-magnitude Q9.6 sequential ALU.
// Handshake: the master holds start high with op/a/b stable. The request is taken on the
// rising edge where start=1 and busy=0. busy stays high until the completion edge. done is a
// one-cycle pulse, and result/ovf/dz are valid from that pulse until the next one.
interface fixed_point_alu_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic        dz;
    logic [1:0]  state_dbg;

    modport master (
        output start, op, a, b,
        input  busy, done, result, ovf, dz, state_dbg
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, ovf, dz, state_dbg
    );
endinterface

// File: rtl/fixed_point_alu_seq.sv
// Sequential add/sub/mul/div for 16-bit sign-magnitude Q9.6 words.
// mul is a 15-step shift-add, and div is a 21-step restoring divide of {a_mag,6'b0} by b_mag.
module fixed_point_alu_seq (
    input  logic                 clk,
    input  logic                 rst_n,
    fixed_point_alu_seq_if.slave bus
);
    localparam int W    = 16;
    localparam int FRAC = 6;
    localparam int MW   = W - 1;
    localparam int DW   = MW + FRAC;
    localparam logic [MW-1:0] MAG_MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, ADDSUB = 2'd1, MUL = 2'd2, DIV = 2'd3} state_t;

    state_t          state, state_nxt;
    logic [4:0]      cnt;
    logic            sa, sb;
    logic [MW-1:0]   ma, mb;
    logic [2*MW-1:0] acc, mcand;
    logic [MW-1:0]   mplier;
    logic [MW-1:0]   rem;
    logic [DW-1:0]   quo;
    logic [MW:0]     rem_sh, rem_diff, as_sum;
    logic            rem_ge;
    logic            fin, fin_sign, fin_ovf, fin_dz;
    logic [MW-1:0]   fin_mag;
    logic            done_r, ovf_r, dz_r;
    logic [W-1:0]    result_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        2'b10:   state_nxt = MUL;
                        2'b11:   state_nxt = DIV;
                        default: state_nxt = ADDSUB;
                    endcase
                end
            end
            default: if (fin) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = done_r;
        bus.result    = result_r;
        bus.ovf       = ovf_r;
        bus.dz        = dz_r;
        bus.state_dbg = state;
    end

    // Completion decode and final result formatting for the active operation.
    always_comb begin
        fin      = 1'b0;
        fin_sign = 1'b0;
        fin_ovf  = 1'b0;
        fin_dz   = 1'b0;
        fin_mag  = '0;
        as_sum   = '0;
        rem_sh   = {rem, quo[DW-1]};
        rem_diff = rem_sh - {1'b0, mb};
        rem_ge   = ~rem_diff[MW];
        case (state)
            ADDSUB: begin
                fin = 1'b1;
                if (sa == sb) begin
                    as_sum   = {1'b0, ma} + {1'b0, mb};
                    fin_sign = sa;
                end else if (ma >= mb) begin
                    as_sum   = {1'b0, ma - mb};
                    fin_sign = sa;
                end else begin
                    as_sum   = {1'b0, mb - ma};
                    fin_sign = sb;
                end
                fin_ovf = as_sum[MW];
                fin_mag = fin_ovf ? MAG_MAX : as_sum[MW-1:0];
            end
            MUL: begin
                fin      = (cnt == 5'(MW));
                fin_sign = sa ^ sb;
                fin_ovf  = |acc[2*MW-1:MW+FRAC];
                fin_mag  = fin_ovf ? MAG_MAX : acc[MW+FRAC-1:FRAC];
            end
            DIV: begin
                fin      = (cnt == 5'd0 && mb == '0) || (cnt == 5'(DW));
                fin_sign = sa ^ sb;
                if (mb == '0) begin
                    fin_dz  = 1'b1;
                    fin_mag = MAG_MAX;
                end else begin
                    fin_ovf = |quo[DW-1:MW];
                    fin_mag = fin_ovf ? MAG_MAX : quo[MW-1:0];
                end
            end
            default: fin = 1'b0;
        endcase
        // A zero magnitude never carries a negative sign.
        if (fin_mag == '0) fin_sign = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            ma       <= '0;
            mb       <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            done_r   <= 1'b0;
            result_r <= '0;
            ovf_r    <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    sa     <= bus.a[W-1];
                    sb     <= (bus.op == 2'b01) ? ~bus.b[W-1] : bus.b[W-1];
                    ma     <= bus.a[MW-1:0];
                    mb     <= bus.b[MW-1:0];
                    cnt    <= '0;
                    acc    <= '0;
                    mcand  <= {{MW{1'b0}}, bus.a[MW-1:0]};
                    mplier <= bus.b[MW-1:0];
                    rem    <= '0;
                    quo    <= {bus.a[MW-1:0], {FRAC{1'b0}}};
                end
            end else if (fin) begin
                done_r   <= 1'b1;
                result_r <= {fin_sign, fin_mag};
                ovf_r    <= fin_ovf;
                dz_r     <= fin_dz;
            end else begin
                cnt <= cnt + 5'd1;
                if (state == MUL) begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end else if (state == DIV) begin
                    rem <= rem_ge ? rem_diff[MW-1:0] : rem_sh[MW-1:0];
                    quo <= {quo[DW-2:0], rem_ge};
                end
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_alu_seq.sv
// Bench for fixed_point_alu_seq: directed cases plus random operations scored against a
// signed-integer reference model.
module tb_fixed_point_alu_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [17:0] exp_q[$];

  fixed_point_alu_seq_if bus ();

  fixed_point_alu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {dz, ovf, sign, mag} from plain integer arithmetic on the encoded values.
  function automatic logic [17:0] model(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int ma, mb, va, vb, sum, mag;
    logic s, ov, dzl;
    logic [15:0] m16;
    ma  = int'(a[14:0]);
    mb  = int'(b[14:0]);
    ov  = 1'b0;
    dzl = 1'b0;
    s   = 1'b0;
    mag = 0;
    case (op)
      2'b00, 2'b01: begin
        va  = a[15] ? -ma : ma;
        vb  = b[15] ? -mb : mb;
        if (op == 2'b01) vb = -vb;
        sum = va + vb;
        s   = (sum < 0);
        mag = s ? -sum : sum;
      end
      2'b10: begin
        mag = (ma * mb) / 64;
        s   = a[15] ^ b[15];
      end
      default: begin
        s = a[15] ^ b[15];
        if (mb == 0) begin
          dzl = 1'b1;
          mag = 32767;
        end else begin
          mag = (ma * 64) / mb;
        end
      end
    endcase
    if (mag > 32767) begin
      mag = 32767;
      ov  = 1'b1;
    end
    if (mag == 0) s = 1'b0;
    m16 = 16'(mag);
    return {dzl, ov, s, m16[14:0]};
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [15:0] b);
    if (op == 2'b10) return 16;
    if (op == 2'b11) return (b[14:0] == 15'd0) ? 1 : 22;
    return 1;
  endfunction

  // Driver: issue one operation, optionally pulse start again poke cycles after acceptance.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int poke);
    logic [17:0] e;
    int lat;
    logic got;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 16'h1234;
        bus.b     = 16'h0567;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    e = exp_q.pop_front();
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(lat), 32'(exp_latency(op, b)));
      check("result", 32'(bus.result), 32'(e[15:0]));
      check("ovf", 32'(bus.ovf), 32'(e[16]));
      check("dz", 32'(bus.dz), 32'(e[17]));
      check("busy_at_done", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("result_held", 32'(bus.result), 32'(e[15:0]));
    end
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = 16'($urandom_range(0, 65535));
      1:       v = {1'($urandom_range(0, 1)), 15'd0};
      default: v = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 2047))};
    endcase
    return v;
  endfunction

  initial begin
    int dones;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_dz", 32'(bus.dz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_op(2'b00, 16'h15C8, 16'h8020, -1);
    check("add_const", 32'(bus.result), 32'h15A8);
    run_op(2'b10, 16'h00A0, 16'h80D0, -1);
    check("mul_const", 32'(bus.result), 32'h8208);
    run_op(2'b11, 16'h15E0, 16'h0080, -1);
    check("div_const", 32'(bus.result), 32'h0AF0);
    run_op(2'b10, 16'h4B00, 16'h0080, -1);
    check("mul_sat", 32'(bus.result), 32'h7FFF);
    check("mul_sat_ovf", 32'(bus.ovf), 32'd1);
    run_op(2'b11, 16'h0040, 16'h8000, -1);
    check("div_zero", 32'(bus.result), 32'hFFFF);
    check("div_zero_dz", 32'(bus.dz), 32'd1);
    run_op(2'b00, 16'h8040, 16'h0040, -1);
    check("add_neg_zero", 32'(bus.result), 32'h0000);
    run_op(2'b01, 16'h0040, 16'h0040, -1);
    check("sub_zero", 32'(bus.result), 32'h0000);
    run_op(2'b01, 16'h7FFF, 16'h8001, -1);
    check("sub_sat_ovf", 32'(bus.ovf), 32'd1);
    run_op(2'b10, 16'h00A0, 16'h80D0, 5);
    check("ignored_start", 32'(bus.result), 32'h8208);
    run_op(2'b11, 16'h0040, 16'h8000, -1);

    // reset while a multiply is in flight
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 16'h00A0;
    bus.b     = 16'h00D0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    check("mid_rst_dz", 32'(bus.dz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);
    check("idle_after_rst", 32'(bus.busy), 32'd0);

    // random operations
    for (int i = 0; i < 150; i++) begin
      run_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
